// File: rtl/freqmeter_result_scheduler.sv
// Round-robin scheduler that shares the frequency meter result path among all
// input channels and delivers {channel, count, timestamp, overrun} over valid/ready.
module freqmeter_result_scheduler #(
    parameter int CHANNELS = 24,
    parameter int CNT_W    = 24,
    parameter int TS_W     = 30,
    parameter int CH_W     = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [CHANNELS-1:0]       ch_mask_i,
    input  logic [CHANNELS-1:0]       ch_done_i,
    input  logic [CHANNELS*CNT_W-1:0] ch_data_i,
    output logic [CHANNELS-1:0]       ch_ack_o,
    input  logic [TS_W-1:0]           ts_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [CH_W-1:0]           res_chan_o,
    output logic [CNT_W-1:0]          res_data_o,
    output logic [TS_W-1:0]           res_ts_o,
    output logic                      res_overrun_o,
    output logic [CHANNELS-1:0]       ovr_sticky_o,
    input  logic [CHANNELS-1:0]       ovr_clr_i,
    output logic                      busy_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] ovr_p_q, ovr_p_d;
    logic [CHANNELS-1:0] sticky_q, sticky_d;
    logic [CHANNELS-1:0] ack_q, ack_d;
    logic [TS_W-1:0]     ts_r_q [CHANNELS];
    logic [TS_W-1:0]     ts_r_d [CHANNELS];
    logic                res_valid_q, res_valid_d;
    logic [CH_W-1:0]     res_chan_q, res_chan_d;
    logic [CNT_W-1:0]    res_data_q, res_data_d;
    logic [TS_W-1:0]     res_ts_q, res_ts_d;
    logic                res_ovr_q, res_ovr_d;
    logic                busy_q, busy_d;

    logic [CNT_W-1:0]    data_arr_s [CHANNELS];
    logic [CHANNELS-1:0] elig_s, done_m_s, win_oh_s, ovr_set_s;
    logic                hi_found_s, lo_found_s, found_s, grant_s;
    logic [CH_W-1:0]     hi_w_s, lo_w_s, win_s;

    // Unpack the flattened count bus into a per-channel array.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            data_arr_s[k] = ch_data_i[k*CNT_W +: CNT_W];
        end
    end

    // Round-robin winner: lowest eligible index at or above ptr, else lowest overall.
    always_comb begin
        elig_s     = pend_q & ch_mask_i;
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_w_s     = '0;
        lo_w_s     = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            lo_found_s = lo_found_s | elig_s[k];
            lo_w_s     = elig_s[k] ? CH_W'(k) : lo_w_s;
            hi_found_s = hi_found_s | (elig_s[k] & (CH_W'(k) >= ptr_q));
            hi_w_s     = (elig_s[k] && (CH_W'(k) >= ptr_q)) ? CH_W'(k) : hi_w_s;
        end
        found_s = hi_found_s | lo_found_s;
        win_s   = hi_found_s ? hi_w_s : lo_w_s;
    end

    // Grant decision and next FSM state.
    always_comb begin
        state_d = state_q;
        grant_s = 1'b0;
        case (state_q)
            IDLE: begin
                grant_s = enable_i & found_s;
                state_d = grant_s ? HOLD : IDLE;
            end
            HOLD: begin
                if (res_ready_i) begin
                    grant_s = enable_i & found_s;
                    state_d = grant_s ? HOLD : IDLE;
                end else begin
                    grant_s = 1'b0;
                    state_d = HOLD;
                end
            end
            default: begin
                grant_s = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Per-channel bookkeeping; a same-cycle done on the winner re-arms it without overrun.
    always_comb begin
        win_oh_s  = grant_s ? (CHANNELS'(1) << win_s) : '0;
        done_m_s  = ch_done_i & ch_mask_i;
        ovr_set_s = done_m_s & pend_q & ~win_oh_s;
        pend_d    = ch_mask_i & (done_m_s | (pend_q & ~win_oh_s));
        ovr_p_d   = ch_mask_i & (ovr_set_s | (ovr_p_q & ~win_oh_s));
        sticky_d  = (sticky_q & ~ovr_clr_i) | ovr_set_s;
        ack_d     = win_oh_s;
        for (int k = 0; k < CHANNELS; k++) begin
            ts_r_d[k] = done_m_s[k] ? ts_i : ts_r_q[k];
        end
    end

    // Result register, pointer and busy flag.
    always_comb begin
        res_valid_d = grant_s | (res_valid_q & ~res_ready_i);
        res_chan_d  = grant_s ? win_s              : res_chan_q;
        res_data_d  = grant_s ? data_arr_s[win_s]  : res_data_q;
        res_ts_d    = grant_s ? ts_r_q[win_s]      : res_ts_q;
        res_ovr_d   = grant_s ? ovr_p_q[win_s]     : res_ovr_q;
        if (grant_s) begin
            ptr_d = (win_s == CH_W'(CHANNELS - 1)) ? '0 : (win_s + CH_W'(1));
        end else begin
            ptr_d = ptr_q;
        end
        busy_d = (|pend_d) | res_valid_d;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            pend_q      <= '0;
            ovr_p_q     <= '0;
            sticky_q    <= '0;
            ack_q       <= '0;
            res_valid_q <= 1'b0;
            res_chan_q  <= '0;
            res_data_q  <= '0;
            res_ts_q    <= '0;
            res_ovr_q   <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                ts_r_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            ovr_p_q     <= ovr_p_d;
            sticky_q    <= sticky_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_chan_q  <= res_chan_d;
            res_data_q  <= res_data_d;
            res_ts_q    <= res_ts_d;
            res_ovr_q   <= res_ovr_d;
            busy_q      <= busy_d;
            for (int k = 0; k < CHANNELS; k++) begin
                ts_r_q[k] <= ts_r_d[k];
            end
        end
    end

    assign ch_ack_o      = ack_q;
    assign res_valid_o   = res_valid_q;
    assign res_chan_o    = res_chan_q;
    assign res_data_o    = res_data_q;
    assign res_ts_o      = res_ts_q;
    assign res_overrun_o = res_ovr_q;
    assign ovr_sticky_o  = sticky_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_freqmeter_result_scheduler.sv
// Bench for freqmeter_result_scheduler: directed scenarios plus random traffic,
// every cycle compared against a queue-free behavioural model of the scheduler.
module tb_freqmeter_result_scheduler;
    localparam int CH    = 24;
    localparam int CNT_W = 24;
    localparam int TS_W  = 30;
    localparam int CH_W  = 5;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                enable_i;
    logic [CH-1:0]       ch_mask_i;
    logic [CH-1:0]       ch_done_i;
    logic [CH*CNT_W-1:0] ch_data_i;
    logic [CH-1:0]       ch_ack_o;
    logic [TS_W-1:0]     ts_i;
    logic                res_valid_o;
    logic                res_ready_i;
    logic [CH_W-1:0]     res_chan_o;
    logic [CNT_W-1:0]    res_data_o;
    logic [TS_W-1:0]     res_ts_o;
    logic                res_overrun_o;
    logic [CH-1:0]       ovr_sticky_o;
    logic [CH-1:0]       ovr_clr_i;
    logic                busy_o;

    always #5 clk = ~clk;

    freqmeter_result_scheduler #(
        .CHANNELS(CH), .CNT_W(CNT_W), .TS_W(TS_W), .CH_W(CH_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .ch_mask_i(ch_mask_i),
        .ch_done_i(ch_done_i), .ch_data_i(ch_data_i), .ch_ack_o(ch_ack_o),
        .ts_i(ts_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_chan_o(res_chan_o), .res_data_o(res_data_o), .res_ts_o(res_ts_o),
        .res_overrun_o(res_overrun_o), .ovr_sticky_o(ovr_sticky_o),
        .ovr_clr_i(ovr_clr_i), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [CH-1:0]    mpend, movr, msticky, mack;
    logic [TS_W-1:0]  mts [CH];
    int               mptr;
    logic             mvalid, movrout, mbusy;
    logic [CH_W-1:0]  mchan;
    logic [CNT_W-1:0] mdata;
    logic [TS_W-1:0]  mtsout;

    function automatic logic [CH-1:0] bit_of(input int k);
        logic [CH-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mpend = '0; movr = '0; msticky = '0; mack = '0;
        for (int k = 0; k < CH; k++) mts[k] = '0;
        mptr = 0; mvalid = 1'b0; movrout = 1'b0; mbusy = 1'b0;
        mchan = '0; mdata = '0; mtsout = '0;
    endtask

    // One clock edge of the scheduler, written from the textual rules.
    task automatic model_step();
        int w;
        logic grant;
        logic [CH-1:0] elig, setovr;
        elig = mpend & ch_mask_i;
        w = -1;
        for (int i = 0; i < CH; i++) begin
            int j;
            j = (mptr + i) % CH;
            if (w < 0 && elig[j]) w = j;
        end
        grant = enable_i && (w >= 0) && (!mvalid || res_ready_i);
        mack = '0;
        if (mvalid && res_ready_i) mvalid = 1'b0;
        if (grant) begin
            mvalid  = 1'b1;
            mchan   = CH_W'(w);
            mdata   = ch_data_i[w*CNT_W +: CNT_W];
            mtsout  = mts[w];
            movrout = movr[w];
            mack[w] = 1'b1;
            mpend[w] = 1'b0;
            movr[w]  = 1'b0;
            mptr = (w + 1) % CH;
        end
        setovr = '0;
        for (int k = 0; k < CH; k++) begin
            if (ch_done_i[k] && ch_mask_i[k]) begin
                if (mpend[k]) setovr[k] = 1'b1;
                mpend[k] = 1'b1;
                mts[k] = ts_i;
                if (setovr[k]) movr[k] = 1'b1;
            end
        end
        msticky = (msticky & ~ovr_clr_i) | setovr;
        mpend = mpend & ch_mask_i;
        movr  = movr & ch_mask_i;
        mbusy = (|mpend) || mvalid;
    endtask

    task automatic compare_all();
        check("valid", 64'(res_valid_o), 64'(mvalid));
        if (mvalid) begin
            check("chan", 64'(res_chan_o), 64'(mchan));
            check("data", 64'(res_data_o), 64'(mdata));
            check("ts", 64'(res_ts_o), 64'(mtsout));
            check("overrun", 64'(res_overrun_o), 64'(movrout));
        end
        check("ack", 64'(ch_ack_o), 64'(mack));
        check("sticky", 64'(ovr_sticky_o), 64'(msticky));
        check("busy", 64'(busy_o), 64'(mbusy));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        ts_i = ts_i + TS_W'(1);
    endtask

    task automatic do_done(input logic [CH-1:0] m);
        ch_done_i = m;
        cycle();
        ch_done_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(res_valid_o), 64'd0);
        check({tag, "_chan"}, 64'(res_chan_o), 64'd0);
        check({tag, "_data"}, 64'(res_data_o), 64'd0);
        check({tag, "_ts"}, 64'(res_ts_o), 64'd0);
        check({tag, "_ovr"}, 64'(res_overrun_o), 64'd0);
        check({tag, "_ack"}, 64'(ch_ack_o), 64'd0);
        check({tag, "_sticky"}, 64'(ovr_sticky_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [CH-1:0] rnd_done;
        rst_i = 1'b0; enable_i = 1'b1; ch_mask_i = '1; ch_done_i = '0;
        ch_data_i = '0; ts_i = '0; res_ready_i = 1'b1; ovr_clr_i = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk); rst_i = 1'b1;
        cycle();

        // Single channel: ch 5, data 0x123456, ts 1000
        ch_data_i[5*CNT_W +: CNT_W] = 24'h123456;
        ts_i = 30'd1000;
        do_done(bit_of(5));
        cycle();
        check("single_valid", 64'(res_valid_o), 64'd1);
        check("single_chan", 64'(res_chan_o), 64'd5);
        check("single_data", 64'(res_data_o), 64'h123456);
        check("single_ts", 64'(res_ts_o), 64'd1000);
        check("single_ovr", 64'(res_overrun_o), 64'd0);
        check("single_ack", 64'(ch_ack_o), 64'(bit_of(5)));
        cycle();
        check("single_ack_once", 64'(ch_ack_o), 64'd0);
        check("single_drop", 64'(res_valid_o), 64'd0);

        // Round-robin fairness from ptr=0
        @(negedge clk); rst_i = 1'b0; model_reset();
        @(negedge clk); rst_i = 1'b1;
        do_done(bit_of(3) | bit_of(7) | bit_of(20));
        cycle(); check("rr_first", 64'(res_chan_o), 64'd3);
        cycle(); check("rr_second", 64'(res_chan_o), 64'd7);
        cycle(); check("rr_third", 64'(res_chan_o), 64'd20);
        cycle(); check("rr_idle", 64'(res_valid_o), 64'd0);
        do_done(bit_of(3) | bit_of(22));
        cycle(); check("rr_wrap_a", 64'(res_chan_o), 64'd22);
        cycle(); check("rr_wrap_b", 64'(res_chan_o), 64'd3);
        cycle();

        // Backpressure on ch 1
        res_ready_i = 1'b0;
        ch_data_i[1*CNT_W +: CNT_W] = CNT_W'($urandom);
        do_done(bit_of(1));
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bp_hold_valid", 64'(res_valid_o), 64'd1);
            check("bp_hold_chan", 64'(res_chan_o), 64'd1);
        end
        res_ready_i = 1'b1;
        cycle();
        check("bp_transfer", 64'(res_valid_o), 64'd0);

        // Overrun on ch 9 while ch 0 occupies HOLD
        res_ready_i = 1'b0;
        do_done(bit_of(0));
        cycle();
        ts_i = 30'd5000;
        do_done(bit_of(9));
        repeat (4) cycle();
        ts_i = 30'd7000;
        do_done(bit_of(9));
        check("ovr_sticky_set", 64'(ovr_sticky_o[9]), 64'd1);
        cycle();
        res_ready_i = 1'b1;
        cycle();
        check("ovr_chan", 64'(res_chan_o), 64'd9);
        check("ovr_flag", 64'(res_overrun_o), 64'd1);
        check("ovr_ts", 64'(res_ts_o), 64'd7000);
        ovr_clr_i = bit_of(9);
        cycle();
        ovr_clr_i = '0;
        check("ovr_sticky_clr", 64'(ovr_sticky_o[9]), 64'd0);

        // Mask and enable
        ch_mask_i = ~bit_of(2);
        do_done(bit_of(2));
        repeat (2) cycle();
        check("mask_valid", 64'(res_valid_o), 64'd0);
        check("mask_busy", 64'(busy_o), 64'd0);
        ch_mask_i = '1;
        enable_i = 1'b0;
        do_done(bit_of(4));
        check("en_busy", 64'(busy_o), 64'd1);
        repeat (3) cycle();
        check("en_no_grant", 64'(res_valid_o), 64'd0);
        ch_mask_i = ~bit_of(4);
        cycle();
        check("maskoff_busy", 64'(busy_o), 64'd0);
        check("maskoff_ack", 64'(ch_ack_o), 64'd0);
        ch_mask_i = '1;
        enable_i = 1'b1;
        repeat (3) cycle();
        check("maskoff_no_result", 64'(res_valid_o), 64'd0);

        // Reset during HOLD
        res_ready_i = 1'b0;
        do_done(bit_of(11));
        cycle();
        check("rst_pre_valid", 64'(res_valid_o), 64'd1);
        #3;
        rst_i = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        @(negedge clk); rst_i = 1'b1;
        res_ready_i = 1'b1;
        repeat (4) cycle();
        check("rst_no_result", 64'(res_valid_o), 64'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rnd_done = '0;
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    rnd_done[k] = 1'b1;
                    ch_data_i[k*CNT_W +: CNT_W] = CNT_W'($urandom);
                end
            end
            res_ready_i = ($urandom_range(0, 3) != 0);
            enable_i    = ($urandom_range(0, 9) != 0);
            ch_mask_i   = ($urandom_range(0, 19) == 0) ? ~bit_of($urandom_range(0, CH - 1)) : '1;
            ovr_clr_i   = ($urandom_range(0, 9) == 0) ? bit_of($urandom_range(0, CH - 1)) : '0;
            do_done(rnd_done);
        end
        ch_mask_i = '1; enable_i = 1'b1; res_ready_i = 1'b1; ovr_clr_i = '0;
        repeat (30) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
